// File: rtl/irq_request_latch.sv
// Interrupt request front-end: synchronises request lines, latches rising edges
// as sticky pending bits, and presents the encoder's choice on a valid/ack handshake.
module irq_request_latch (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic [3:0] mask,
    output logic [3:0] pend_out,
    input  logic [1:0] enc_idx,
    output logic       irq_valid,
    output logic [1:0] irq_idx,
    input  logic       irq_ack,
    output logic [3:0] overrun,
    input  logic       ovr_clr
);

    localparam int unsigned N_CH  = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [N_CH-1:0]   sync1;
    logic [N_CH-1:0]   sync2;
    logic [N_CH-1:0]   prev;
    logic [N_CH-1:0]   pend;
    logic [N_CH-1:0]   pend_nxt;
    logic [N_CH-1:0]   overrun_nxt;
    logic [N_CH-1:0]   rise;
    logic [N_CH-1:0]   clr;
    logic              irq_valid_nxt;
    logic [IDX_W-1:0]  irq_idx_nxt;

    // Masked channels still accumulate; the mask only hides them from the encoder.
    assign pend_out = pend & ~mask;

    // Edge detect and pending/overrun update; a new edge wins over a same-cycle clear.
    always_comb begin
        rise        = sync2 & ~prev;
        clr         = (state == PRESENT && irq_ack) ? (N_CH'(1) << irq_idx) : '0;
        pend_nxt    = rise | (pend & ~clr);
        overrun_nxt = (rise & pend & ~clr) | (overrun & ~{N_CH{ovr_clr}});
    end

    // Presentation FSM: IDLE always spends one cycle before re-presenting.
    always_comb begin
        state_nxt     = state;
        irq_valid_nxt = irq_valid;
        irq_idx_nxt   = irq_idx;
        case (state)
            IDLE: begin
                irq_valid_nxt = 1'b0;
                if (pend_out != '0) begin
                    irq_idx_nxt   = enc_idx;
                    irq_valid_nxt = 1'b1;
                    state_nxt     = PRESENT;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    irq_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                irq_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            pend      <= '0;
            overrun   <= '0;
            irq_valid <= 1'b0;
            irq_idx   <= '0;
            state     <= IDLE;
        end else begin
            sync1     <= req_in;
            sync2     <= sync1;
            prev      <= sync2;
            pend      <= pend_nxt;
            overrun   <= overrun_nxt;
            irq_valid <= irq_valid_nxt;
            irq_idx   <= irq_idx_nxt;
            state     <= state_nxt;
        end
    end

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch with a behavioural priority encoder in the loop.
module tb_irq_request_latch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic [3:0] pend_out;
    logic [1:0] enc_idx;
    logic       irq_valid;
    logic [1:0] irq_idx;
    logic       irq_ack;
    logic [3:0] overrun;
    logic       ovr_clr;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] msk;
        logic       ack;
        logic       oclr;
        logic       v;
        logic [1:0] idx;
        logic [3:0] po;
        logic [3:0] ovr;
    } vec_t;

    vec_t vecs[$];

    irq_request_latch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .mask      (mask),
        .pend_out  (pend_out),
        .enc_idx   (enc_idx),
        .irq_valid (irq_valid),
        .irq_idx   (irq_idx),
        .irq_ack   (irq_ack),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    // Encoder: highest set bit wins
    always_comb begin
        enc_idx = 2'd0;
        for (int k = 0; k < 4; k++)
            if (pend_out[k]) enc_idx = 2'(k);
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] m, input logic a,
                                input logic c, input logic v, input logic [1:0] i,
                                input logic [3:0] p, input logic [3:0] o);
        vec_t t;
        t.req = r; t.msk = m; t.ack = a; t.oclr = c;
        t.v = v; t.idx = i; t.po = p; t.ovr = o;
        return t;
    endfunction

    task automatic step(input logic [3:0] r, input logic a);
        req_in  = r;
        irq_ack = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_in = '0; mask = '0; irq_ack = 1'b0; ovr_clr = 1'b0;

        // 1: single channel, 4-edge latency, ack clears
        vecs.push_back(mk(4'b0100, 4'h0, 0, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0100, 4'h0, 0, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0100, 4'h0, 0, 0, 0, 2'd0, 4'b0100, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 1, 2'd2, 4'b0100, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 1, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 2'd0, 4'b0000, 4'h0));
        // 2: three channels at once, served 3,1,0; ack in IDLE is ignored
        vecs.push_back(mk(4'b1011, 4'h0, 0, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 2'd0, 4'b1011, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 1, 2'd3, 4'b1011, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 1, 0, 0, 2'd0, 4'b0011, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 1, 0, 1, 2'd1, 4'b0011, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 1, 0, 0, 2'd0, 4'b0001, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 1, 2'd0, 4'b0001, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 1, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 2'd0, 4'b0000, 4'h0));
        // 3: overrun on channel 1, then ovr_clr, then ack
        vecs.push_back(mk(4'b0010, 4'h0, 0, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 2'd0, 4'b0010, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 1, 2'd1, 4'b0010, 4'h0));
        vecs.push_back(mk(4'b0010, 4'h0, 0, 0, 1, 2'd1, 4'b0010, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 1, 2'd1, 4'b0010, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 1, 2'd1, 4'b0010, 4'b0010));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 1, 1, 2'd1, 4'b0010, 4'b0000));
        vecs.push_back(mk(4'b0000, 4'h0, 1, 0, 0, 2'd0, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 2'd0, 4'b0000, 4'b0000));
        // 4: mask hides channel 3; unmasking does not retract presentation of 2
        vecs.push_back(mk(4'b1100, 4'b1000, 0, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'b1000, 0, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'b1000, 0, 0, 0, 2'd0, 4'b0100, 4'h0));
        vecs.push_back(mk(4'b0000, 4'b1000, 0, 0, 1, 2'd2, 4'b0100, 4'h0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 0, 1, 2'd2, 4'b1100, 4'h0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1, 0, 0, 2'd0, 4'b1000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 0, 1, 2'd3, 4'b1000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1, 0, 0, 2'd0, 4'b0000, 4'h0));
        // 5: new edge on channel 2 coincides with its ack
        vecs.push_back(mk(4'b0100, 4'h0, 0, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 2'd0, 4'b0100, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 1, 2'd2, 4'b0100, 4'h0));
        vecs.push_back(mk(4'b0100, 4'h0, 0, 0, 1, 2'd2, 4'b0100, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 1, 2'd2, 4'b0100, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 1, 0, 0, 2'd0, 4'b0100, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 1, 2'd2, 4'b0100, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 1, 0, 0, 2'd0, 4'b0000, 4'h0));
        vecs.push_back(mk(4'b0000, 4'h0, 0, 0, 0, 2'd0, 4'b0000, 4'h0));

        repeat (3) @(posedge clk);
        #1;
        chk("reset valid",    {3'b0, irq_valid}, 4'h0);
        chk("reset idx",      {2'b0, irq_idx},   4'h0);
        chk("reset pend_out", pend_out,          4'h0);
        chk("reset overrun",  overrun,           4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            req_in  = vecs[i].req;
            mask    = vecs[i].msk;
            irq_ack = vecs[i].ack;
            ovr_clr = vecs[i].oclr;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d valid", i),    {3'b0, irq_valid}, {3'b0, vecs[i].v});
            chk($sformatf("row%0d pend_out", i), pend_out,          vecs[i].po);
            chk($sformatf("row%0d overrun", i),  overrun,           vecs[i].ovr);
            if (vecs[i].v)
                chk($sformatf("row%0d idx", i), {2'b0, irq_idx}, {2'b0, vecs[i].idx});
        end
        mask = '0; ovr_clr = 1'b0;

        // 6: held request, async reset mid-PRESENT, one event after release
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        chk("held valid pre-reset", {3'b0, irq_valid}, 4'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid",    {3'b0, irq_valid}, 4'h0);
        chk("async rst pend_out", pend_out,          4'h0);
        chk("async rst idx",      {2'b0, irq_idx},   4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        chk("post-rst E1 pend_out", pend_out, 4'h0);
        step(4'b0001, 1'b0);
        chk("post-rst E2 pend_out", pend_out,          4'b0001);
        chk("post-rst E2 valid",    {3'b0, irq_valid}, 4'h0);
        step(4'b0001, 1'b0);
        chk("post-rst E3 valid", {3'b0, irq_valid}, 4'h1);
        chk("post-rst E3 idx",   {2'b0, irq_idx},   4'h0);
        step(4'b0001, 1'b1);
        chk("held ack valid", {3'b0, irq_valid}, 4'h0);
        for (int n = 0; n < 4; n++) begin
            step(4'b0001, 1'b0);
            chk($sformatf("held no re-event %0d valid", n), {3'b0, irq_valid}, 4'h0);
            chk($sformatf("held no re-event %0d pend", n),  pend_out,          4'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_request_latch.md
Name: irq_request_latch

Overview:
- Upstream front-end for the 4-input priority encoder (inputs i0..i3, encoded output y[1:0]).
- Synchronises four asynchronous request lines, detects rising edges and holds them as sticky pending bits. Drives the masked pending vector into the encoder.
- Takes the encoder's index back, latches it, and presents it to the consumer on a valid/ack handshake. Clears the serviced bit on ack and flags overruns.

Parameters:
- NONE_FIXED_WIDTH, n/a, channel count is fixed at 4 to match the encoder; block has no parameters.

Ports:
- clk  input  1  system clock; all flops on rising edge.
- rst_n  input  1  asynchronous active-low reset; all state cleared while low.
- req_in  input  4  asynchronous request lines; bit k = channel k.
- mask  input  4  synchronous mask; 1 = channel k not presented (still latched).
- pend_out  output  4  pend & ~mask; wired to encoder i0..i3 (bit k -> ik).
- enc_idx  input  2  encoder output y; highest set bit of pend_out.
- irq_valid  output  1  irq_idx holds a serviceable channel.
- irq_idx  output  2  channel being presented; stable while irq_valid=1.
- irq_ack  input  1  consumer accepts irq_idx; sampled only when irq_valid=1.
- overrun  output  4  sticky: new edge on channel k while pend[k] already 1.
- ovr_clr  input  1  clears all overrun bits.

Behaviour:
- Reset values:
  - sync1, sync2, prev, pend, overrun = 4'b0.
  - irq_valid = 0, irq_idx = 2'd0, state = IDLE.
  - pend_out = 0.
- Synchroniser: sync1 <= req_in; sync2 <= sync1; prev <= sync2; rise = sync2 & ~prev (combinational).
- Pending, per bit k, each edge:
  - clr_k = (state==PRESENT & irq_ack & irq_idx==k).
  - pend[k] <= rise[k] | (pend[k] & ~clr_k). Set wins over clear.
- Overrun, per bit k:
  - overrun[k] <= (rise[k] & pend[k] & ~clr_k) | (overrun[k] & ~ovr_clr). Set wins over ovr_clr.
  - Edge arriving on the same cycle as its ack: no overrun, pend stays 1.
- pend_out is combinational from registered pend and live mask. The encoder path is combinational and settles within the cycle.
- FSM, 2 states:
  - IDLE: if pend_out != 0 -> irq_idx <= enc_idx, irq_valid <= 1, go PRESENT. Else stay, irq_valid = 0.
  - PRESENT: irq_valid = 1, irq_idx frozen.
    - On irq_ack: clear pend[irq_idx] (per rule above), irq_valid <= 0, go IDLE.
    - No ack: hold indefinitely.
- Latency: req_in high before edge E0 -> sync1 at E0, sync2 at E1, pend set at E2, irq_valid=1 after E3. Total 4 clock edges, zero-cycle encoder.
- Throughput: one ack per 2 cycles minimum. IDLE always inserts one cycle with irq_valid=0 between presentations.
- Mask changes:
  - Affect pend_out immediately.
  - Do not retract a presentation already in PRESENT; the masked channel is still acked and cleared normally.
  - Masked channels accumulate pending and overrun.
- irq_ack while irq_valid=0 is ignored.
- req_in held high: one event only; a new event needs low for at least 1 sampled cycle, then high.
- Reset mid-operation: everything clears asynchronously. A req_in already high at reset release is treated as a rising edge (prev=0) and produces one event.
- Priority: channel 3 highest, 0 lowest, fixed by the encoder. Not re-evaluated while in PRESENT.

Test Plan:
1. Reset, then pulse req_in=4'b0100 for 3 cycles, mask=0 -> irq_valid rises 4 edges after first sample, irq_idx=2. Ack -> pend=0, irq_valid=0 next cycle, stays IDLE.
2. req_in=4'b1011 simultaneously, ack each presentation immediately -> irq_idx sequence 3,1,0, each separated by one idle cycle; pend=0 at end.
3. Channel 1 pending, no ack, pulse req_in[1] again (low-high) -> overrun=4'b0010. Assert ovr_clr -> overrun=0. Ack -> pend[1]=0.
4. mask=4'b1000 with pend channels 3 and 2 -> pend_out=4'b0100, irq_idx=2. Clear mask while presenting 2 -> irq_idx stays 2 until ack, then next presentation is 3.
5. Ack channel 2 on the same cycle its new rising edge arrives -> pend[2] stays 1, overrun[2]=0, channel 2 re-presented after one idle cycle.
6. req_in=4'b0001 held high, drop rst_n mid-PRESENT -> all outputs 0 immediately. Release -> one new event, irq_idx=0, irq_valid after 4 edges.
